rr_arbiter8: RTL and testbench
==============================

RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, default 16, maximum grant-hold cycles before forced release (used only with ARB_TIMEOUT_EN).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: req  input  8  per-requester request, bit i = requester i.
REQ-005 SHALL have port: done  input  1  current owner releases the resource this cycle.
REQ-006 SHALL have port: gnt  output  8  one-hot grant, registered.
REQ-007 SHALL have port: gnt_idx  output  3  binary index of granted requester, registered.
REQ-008 SHALL have port: gnt_valid  output  1  high while a grant is held.
REQ-009 SHALL have port: timeout  output  1  one-cycle pulse on forced release.

Function
REQ-010 SHALL implement two states: IDLE (no owner) and GRANT (owner held).
REQ-011 In IDLE with req != 0: SHALL select the first set req bit searching ptr, ptr+1, ..., wrapping 7->0, and enter GRANT; gnt/gnt_idx/gnt_valid valid the next cycle (1-cycle latency).
REQ-012 In IDLE with req == 0: SHALL stay IDLE, gnt = 0, gnt_valid = 0.
REQ-013 gnt SHALL always equal one-hot decode of gnt_idx when gnt_valid = 1, and SHALL be 8'h00 when gnt_valid = 0.
REQ-014 In GRANT: grant SHALL hold unchanged regardless of other req bits.
REQ-015 In GRANT, done = 1 or req[gnt_idx] = 0 SHALL release: next cycle state IDLE, gnt = 0, gnt_valid = 0; gnt_idx holds its last value.
REQ-016 On release, ptr SHALL become (gnt_idx + 1) mod 8 (wrap 7 -> 0).
REQ-017 After release, the earliest next grant SHALL appear two cycles after done (one mandatory idle cycle).
REQ-018 done while in IDLE SHALL be ignored.
REQ-019 Every requester continuously asserting req SHALL be granted within 8 grants (no starvation).

Reset
REQ-020 rst = 1 SHALL immediately force state IDLE, ptr = 0, gnt = 8'h00, gnt_idx = 3'd0, gnt_valid = 0, timeout = 0, hold counter = 0.
REQ-021 Reset asserted mid-grant SHALL drop the grant without a timeout pulse; after deassertion arbitration SHALL restart from ptr = 0.

Configuration
REQ-022 With macro ARB_TIMEOUT_EN defined: a hold counter SHALL count cycles in GRANT; on reaching TIMEOUT_CYCLES without release, SHALL force release as in REQ-015/016 and pulse timeout for one cycle.
REQ-023 Without ARB_TIMEOUT_EN: no counter SHALL be built, timeout SHALL be tied 0, grants held indefinitely.
REQ-024 Release by done and timeout in the same cycle SHALL count as a normal release, timeout = 0.

Structure
REQ-025 Shared package arb_pkg SHALL hold N_REQ = 8, IDX_W = 3, and the state encoding (IDLE, GRANT).
REQ-026 A sub-module rr_pick8 SHALL perform the combinational rotate-and-priority-encode (req, ptr -> idx, any); all registers reside in rr_arbiter8.

Verification
REQ-027 Reset, req = 8'h00 -> gnt = 0, gnt_valid = 0, gnt_idx = 0 indefinitely.
REQ-028 After reset req = 8'h24 -> gnt = 8'h04, gnt_idx = 2 one cycle later; done -> next grant gnt = 8'h20, gnt_idx = 5.
REQ-029 req = 8'hFF held, done after each grant -> gnt_idx sequence 0,1,...,7,0 (wrap verified).
REQ-030 Owner 3 granted, req changes to 8'hF0 without done -> release on req[3] drop, then gnt_idx = 4.
REQ-031 ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 4, req = 8'h01 held, no done -> timeout pulses once at cycle 4 of grant, gnt drops, re-grant to 0 after idle cycle.
REQ-032 rst asserted during grant to 6 -> gnt = 0 asynchronously; after release with req = 8'h41 -> gnt_idx = 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // One-hot decode of a requester index.
    function automatic logic [N_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        idx_onehot      = '0;
        idx_onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping 7 -> 0.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   off;

    // Rotating the doubled vector puts requester ptr at bit 0.
    assign dbl = {req, req} >> ptr;
    assign rot = dbl[N_REQ-1:0];
    assign any = |req;

    // Lowest set bit of the rotated vector, offset back by ptr.
    always_comb begin
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
        idx = ptr + off;
    end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with held grants and registered outputs.
// Optional forced release after TIMEOUT_CYCLES grant cycles: define ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no owner; pick next requester from ptr onward
// GRANT | owner held until done, request drop or (optionally) hold timeout
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    rr_pick8 u_pick (
        .req (req),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(TIMEOUT_CYCLES - 1);

    // Down-counter: loaded on grant, terminal count 0 marks the last allowed cycle.
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              to_q, to_nxt;

    assign timeout = to_q;
`else
    assign timeout = 1'b0;
`endif

    // Next-state, pointer and grant index selection.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = gnt_idx;
`ifdef ARB_TIMEOUT_EN
        hold_nxt  = hold_cnt;
        to_nxt    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt = GRANT;
                    idx_nxt   = pick_idx;
`ifdef ARB_TIMEOUT_EN
                    hold_nxt  = HOLD_LOAD;
`endif
                end
            end
            GRANT: begin
                if (done || !req[gnt_idx]) begin
                    state_nxt = IDLE;
                    ptr_nxt   = gnt_idx + 3'd1;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_cnt == '0) begin
                    state_nxt = IDLE;
                    ptr_nxt   = gnt_idx + 3'd1;
                    to_nxt    = 1'b1;
                end else begin
                    hold_nxt  = hold_cnt - 1'b1;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and registered outputs; reset drops any grant immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= '0;
            to_q      <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            gnt_idx   <= idx_nxt;
            gnt_valid <= (state_nxt == GRANT);
            gnt       <= (state_nxt == GRANT) ? idx_onehot(idx_nxt) : '0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= hold_nxt;
            to_q      <= to_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus random traffic
// against a behavioural round-robin model.
module tb_rr_arbiter8;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    // Model state: the visible outputs plus the rotation pointer and grant age.
    bit       m_valid;
    int       m_idx;
    int       m_ptr;
    bit       m_to;
    int       m_hold;

    rr_arbiter8 #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_idx = 0; m_ptr = 0; m_to = 0; m_hold = 0;
    endtask

    task automatic model_step(input logic [7:0] r, input logic d);
        m_to = 0;
        if (!m_valid) begin
            if (r != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    if (r[(m_ptr + k) % 8]) begin
                        m_idx = (m_ptr + k) % 8;
                        break;
                    end
                end
                m_valid = 1;
                m_hold  = 1;
            end
        end else if (d || !r[m_idx]) begin
            m_valid = 0;
            m_ptr   = (m_idx + 1) % 8;
`ifdef ARB_TIMEOUT_EN
        end else if (m_hold == TO) begin
            m_valid = 0;
            m_ptr   = (m_idx + 1) % 8;
            m_to    = 1;
`endif
        end else begin
            m_hold++;
        end
    endtask

    task automatic check_model(input string tag);
        logic [7:0] eg;
        eg = m_valid ? (8'h01 << m_idx) : 8'h00;
        chk({tag, ".gnt"}, gnt, eg);
        chk({tag, ".gnt_valid"}, {7'd0, gnt_valid}, {7'd0, m_valid});
        chk({tag, ".gnt_idx"}, {5'd0, gnt_idx}, 8'(m_idx));
        chk({tag, ".timeout"}, {7'd0, timeout}, {7'd0, m_to});
    endtask

    // One clock: inputs applied at the falling edge, outputs checked at the next one.
    task automatic tick(input string tag, input logic [7:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        model_step(r, d);
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 8'h00;
        done = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] r;
        logic       d;

        // Reset state and quiet bus.
        model_reset();
        #2;
        check_model("reset");
        do_reset();
        for (int i = 0; i < 4; i++) tick("idle", 8'h00, 1'b0);
        tick("idle_done", 8'h00, 1'b1);
        chk("idle_gnt_const", gnt, 8'h00);

        // Two requesters, release by done, pointer advance.
        tick("r24_a", 8'h24, 1'b0);
        chk("r24_gnt2", gnt, 8'h04);
        chk("r24_idx2", {5'd0, gnt_idx}, 8'd2);
        tick("r24_hold", 8'h24, 1'b0);
        tick("r24_done", 8'h24, 1'b1);
        chk("r24_release", gnt, 8'h00);
        chk("r24_idx_held", {5'd0, gnt_idx}, 8'd2);
        tick("r24_b", 8'h24, 1'b0);
        chk("r24_gnt5", gnt, 8'h20);
        chk("r24_idx5", {5'd0, gnt_idx}, 8'd5);

        // All requesting: full rotation with wrap back to 0.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            tick("ff_grant", 8'hFF, 1'b0);
            chk("ff_seq", {5'd0, gnt_idx}, 8'(k % 8));
            tick("ff_rel", 8'hFF, 1'b1);
        end

        // Owner drops its request: release, then next in rotation.
        do_reset();
        tick("own3", 8'h08, 1'b0);
        chk("own3_idx", {5'd0, gnt_idx}, 8'd3);
        tick("own3_drop", 8'hF0, 1'b0);
        chk("own3_rel", {7'd0, gnt_valid}, 8'd0);
        tick("own4", 8'hF0, 1'b0);
        chk("own4_idx", {5'd0, gnt_idx}, 8'd4);

        // Long hold on a single requester.
        do_reset();
        for (int i = 0; i < TO; i++) tick("hold", 8'h01, 1'b0);
        chk("hold_gnt", gnt, 8'h01);
        tick("hold_end", 8'h01, 1'b0);
`ifdef ARB_TIMEOUT_EN
        chk("to_pulse", {7'd0, timeout}, 8'd1);
        chk("to_gnt_drop", gnt, 8'h00);
        tick("to_regrant", 8'h01, 1'b0);
        chk("to_regrant_gnt", gnt, 8'h01);
        chk("to_pulse_once", {7'd0, timeout}, 8'd0);
`else
        for (int i = 0; i < 20; i++) tick("hold_forever", 8'h01, 1'b0);
        chk("hold_forever_gnt", gnt, 8'h01);
        chk("hold_no_to", {7'd0, timeout}, 8'd0);
`endif

        // Asynchronous reset during a grant to 6, then restart from pointer 0.
        do_reset();
        tick("g6", 8'h40, 1'b0);
        chk("g6_idx", {5'd0, gnt_idx}, 8'd6);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_gnt", gnt, 8'h00);
        chk("async_valid", {7'd0, gnt_valid}, 8'd0);
        chk("async_idx", {5'd0, gnt_idx}, 8'd0);
        chk("async_to", {7'd0, timeout}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        tick("r41", 8'h41, 1'b0);
        chk("r41_idx0", {5'd0, gnt_idx}, 8'd0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            r = 8'($urandom);
            if ($urandom_range(0, 7) == 0) r = 8'h00;
            if (m_valid && $urandom_range(0, 3) != 0) r[m_idx] = 1'b1;
            d = ($urandom_range(0, 4) == 0);
            tick("rand", r, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
